// File: rtl/gate_pkg.sv
// Shared op codes, FSM encoding and bitwise helpers for the gate datapath.
package gate_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOTA = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  typedef enum logic {
    ST_IDLE,
    ST_ACCUM
  } state_t;

  function automatic logic [63:0] bit_op(
    input logic [2:0]  op,
    input logic [63:0] a,
    input logic [63:0] b
  );
    case (op)
      OP_AND:  bit_op = a & b;
      OP_OR:   bit_op = a | b;
      OP_NAND: bit_op = ~(a & b);
      OP_NOR:  bit_op = ~(a | b);
      OP_XOR:  bit_op = a ^ b;
      OP_XNOR: bit_op = ~(a ^ b);
      OP_NOTA: bit_op = ~a;
      default: bit_op = '0;
    endcase
  endfunction

  // Burst fold chosen by the op of the first beat.
  function automatic logic [63:0] comb_op(
    input logic [2:0]  op,
    input logic [63:0] acc,
    input logic [63:0] r
  );
    case (op)
      OP_AND, OP_NAND:          comb_op = acc & r;
      OP_OR, OP_NOR:            comb_op = acc | r;
      OP_XOR, OP_XNOR, OP_NOTA: comb_op = acc ^ r;
      default:                  comb_op = '0;
    endcase
  endfunction

endpackage

// File: rtl/gate_skid_buf.sv
// Two-entry FIFO; accepts up to two pushes per cycle into free slots.
module gate_skid_buf #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push0,
  input  logic          push1,
  input  logic [DW-1:0] d0,
  input  logic [DW-1:0] d1,
  input  logic          pop,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          empty,
  output logic          full
);

  logic [DW-1:0] m0_q, m0_d;
  logic [DW-1:0] m1_q, m1_d;
  logic [1:0]    cnt_q, cnt_d;

  // Head always lives in m0; pop shifts before pushes land.
  always_comb begin
    m0_d  = m0_q;
    m1_d  = m1_q;
    cnt_d = cnt_q;
    if (pop) begin
      m0_d  = m1_q;
      cnt_d = cnt_d - 2'd1;
    end
    if (push0) begin
      if (cnt_d == 2'd0) m0_d = d0;
      else               m1_d = d0;
      cnt_d = cnt_d + 2'd1;
    end
    if (push1) begin
      m1_d  = d1;
      cnt_d = cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_q  <= '0;
      m1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      m0_q  <= m0_d;
      m1_q  <= m1_d;
      cnt_q <= cnt_d;
    end
  end

  assign empty     = (cnt_q == 2'd0);
  assign full      = (cnt_q == 2'd2);
  assign out_valid = !empty;
  assign out_data  = empty ? '0 : m0_q;

endmodule

// File: rtl/gate_logic_pipe.sv
// Registered selectable bitwise op with reduce bursts and skid output.
import gate_pkg::*;

module gate_logic_pipe #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_reduce,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic [CNT_W-1:0] done_cnt
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [2:0]       first_op_q, first_op_d;
  logic             err_acc_q, err_acc_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

  logic [WIDTH-1:0] r, acc_c;
  logic             r_err, err_c, fire, pop;
  logic             push0, push1, buf_empty, buf_full;
  logic [WIDTH:0]   d0, d1, buf_out;

  // An abort pushes two entries, so ACCUM waits for an empty buffer.
  assign in_ready = !rst &&
    ((state_q == ST_ACCUM) ? buf_empty : !buf_full);
  assign fire = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    r     = WIDTH'(bit_op(in_op, 64'(in_a), 64'(in_b)));
    r_err = (in_op == OP_RSVD);
    acc_c = WIDTH'(comb_op(first_op_q, 64'(acc_q), 64'(r)));
    err_c = err_acc_q | (in_op != first_op_q) | r_err;
    state_d    = state_q;
    acc_d      = acc_q;
    first_op_d = first_op_q;
    err_acc_d  = err_acc_q;
    push0 = 1'b0;
    push1 = 1'b0;
    d0    = {r_err, r};
    d1    = {r_err, r};
    if (fire) begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_reduce && !in_last) begin
            state_d    = ST_ACCUM;
            acc_d      = r;
            first_op_d = in_op;
            err_acc_d  = r_err;
          end else begin
            push0 = 1'b1;
          end
        end
        ST_ACCUM: begin
          if (!in_reduce) begin
            push0   = 1'b1;
            d0      = {1'b1, acc_q};
            push1   = 1'b1;
            state_d = ST_IDLE;
          end else if (in_last) begin
            push0   = 1'b1;
            d0      = {err_c, acc_c};
            state_d = ST_IDLE;
          end else begin
            acc_d     = acc_c;
            err_acc_d = err_c;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    done_cnt_d = done_cnt_q;
    if (pop && (done_cnt_q != {CNT_W{1'b1}}))
      done_cnt_d = done_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      first_op_q <= OP_AND;
      err_acc_q  <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      first_op_q <= first_op_d;
      err_acc_q  <= err_acc_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  gate_skid_buf #(.DW(WIDTH + 1)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push0     (push0),
    .push1     (push1),
    .d0        (d0),
    .d1        (d1),
    .pop       (pop),
    .out_valid (out_valid),
    .out_data  (buf_out),
    .empty     (buf_empty),
    .full      (buf_full)
  );

  assign {out_err, out_data} = buf_out;
  assign done_cnt = done_cnt_q;

endmodule

// File: tb/tb_gate_logic_pipe.sv
// Directed scoreboard bench for gate_logic_pipe (WIDTH=3, CNT_W=4).
module tb_gate_logic_pipe;

  localparam int W  = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [2:0]    in_op = '0;
  logic          in_reduce = 1'b0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic          out_err;
  logic [CW-1:0] done_cnt;

  int n_pass = 0;
  int n_chk  = 0;
  logic [3:0] q[$];

  gate_logic_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_reduce (in_reduce),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .done_cnt  (done_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick(output bit acc);
    logic [3:0] e;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_out", {out_err, out_data}, 16'hdead);
      end else begin
        e = q.pop_front();
        chk("out", 16'({out_err, out_data}), 16'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  task automatic send(input logic [2:0] a, input logic [2:0] b,
                      input logic [2:0] op, input bit red,
                      input bit last, input int ne,
                      input logic [3:0] e1, input logic [3:0] e2);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_op = op;
    in_reduce = red;
    in_last = last;
    for (int i = 0; i < 20; i++) begin
      tick(acc);
      if (acc) break;
    end
    in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 16'(acc), 16'd1);
    if (acc && ne > 0) q.push_back(e1);
    if (acc && ne > 1) q.push_back(e2);
  endtask

  task automatic drain();
    bit acc;
    in_valid = 1'b0;
    for (int i = 0; i < 30 && q.size() > 0; i++) tick(acc);
    chk("drain", 16'(q.size()), 16'd0);
  endtask

  initial begin
    #1;
    chk("rst_in_ready", 16'(in_ready), 16'd0);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_out_data", 16'(out_data), 16'd0);
    chk("rst_out_err", 16'(out_err), 16'd0);
    chk("rst_done_cnt", 16'(done_cnt), 16'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 16'(in_ready), 16'd1);

    send(3'b000, 3'b010, 3'd2, 0, 0, 1, 4'b0111, 4'b0);
    chk("latency1_valid", 16'(out_valid), 16'd1);
    send(3'b111, 3'b101, 3'd2, 0, 0, 1, 4'b0010, 4'b0);
    send(3'b001, 3'b011, 3'd2, 0, 0, 1, 4'b0110, 4'b0);
    drain();
    chk("done_cnt_3", 16'(done_cnt), 16'd3);

    send(3'b110, 3'b011, 3'd0, 0, 0, 1, 4'b0010, 4'b0);
    send(3'b110, 3'b011, 3'd1, 0, 0, 1, 4'b0111, 4'b0);
    send(3'b110, 3'b011, 3'd2, 0, 0, 1, 4'b0101, 4'b0);
    send(3'b110, 3'b011, 3'd3, 0, 0, 1, 4'b0000, 4'b0);
    send(3'b110, 3'b011, 3'd4, 0, 0, 1, 4'b0101, 4'b0);
    send(3'b110, 3'b011, 3'd5, 0, 0, 1, 4'b0010, 4'b0);
    send(3'b110, 3'b011, 3'd6, 0, 0, 1, 4'b0001, 4'b0);
    send(3'b110, 3'b011, 3'd7, 0, 0, 1, 4'b1000, 4'b0);
    drain();
    chk("done_cnt_11", 16'(done_cnt), 16'd11);

    out_ready = 1'b0;
    send(3'b111, 3'b101, 3'd0, 0, 0, 1, 4'b0101, 4'b0);
    send(3'b111, 3'b000, 3'd1, 0, 0, 1, 4'b0111, 4'b0);
    in_valid = 1'b1;
    in_a = 3'b011;
    in_b = 3'b001;
    in_op = 3'd4;
    #1;
    chk("bp_in_ready_low", 16'(in_ready), 16'd0);
    idle(2);
    chk("bp_hold_data", 16'({out_err, out_data}), 16'b0101);
    out_ready = 1'b1;
    send(3'b011, 3'b001, 3'd4, 0, 0, 1, 4'b0010, 4'b0);
    drain();
    chk("done_cnt_14", 16'(done_cnt), 16'd14);

    send(3'b111, 3'b000, 3'd4, 1, 0, 0, 4'b0, 4'b0);
    chk("reduce_no_out1", 16'(out_valid), 16'd0);
    send(3'b011, 3'b000, 3'd4, 1, 0, 0, 4'b0, 4'b0);
    chk("reduce_no_out2", 16'(out_valid), 16'd0);
    send(3'b001, 3'b000, 3'd4, 1, 1, 1, 4'b0101, 4'b0);
    drain();
    send(3'b111, 3'b000, 3'd4, 1, 0, 0, 4'b0, 4'b0);
    send(3'b011, 3'b000, 3'd5, 1, 0, 0, 4'b0, 4'b0);
    send(3'b001, 3'b000, 3'd4, 1, 1, 1, 4'b1010, 4'b0);
    drain();

    send(3'b110, 3'b011, 3'd0, 1, 0, 0, 4'b0, 4'b0);
    send(3'b111, 3'b101, 3'd0, 0, 0, 2, 4'b1010, 4'b0101);
    drain();
    chk("done_cnt_sat", 16'(done_cnt), 16'd15);

    out_ready = 1'b0;
    send(3'b000, 3'b000, 3'd1, 0, 0, 1, 4'b0000, 4'b0);
    send(3'b111, 3'b000, 3'd4, 1, 0, 0, 4'b0, 4'b0);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 16'(out_valid), 16'd0);
    chk("async_rst_done_cnt", 16'(done_cnt), 16'd0);
    chk("async_rst_in_ready", 16'(in_ready), 16'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rerun_in_ready", 16'(in_ready), 16'd1);
    send(3'b111, 3'b101, 3'd2, 0, 0, 1, 4'b0010, 4'b0);
    chk("rerun_latency", 16'(out_valid), 16'd1);
    drain();
    chk("rerun_done_cnt", 16'(done_cnt), 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
